decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Control unit directly downstream of the fetch register: consumes the 4-bit instruction/operand pair and the current program byte.
- Sequences the machine through fetch/execute phases and drives every control strobe: PC increment/load, fetch-register enable, ALU function, accumulator and flag enables, I/O bus strobes.
- Two-byte jump instructions take their 12-bit target from the operand nibble (high) plus the following ROM byte (low).

Parameters:
- ALU_W, 3, width of alu_fn.
- FN_PASSB, 3'b000, ALU code: result = operand B.
- FN_ADD, 3'b011, ALU code: A + B.
- FN_SUB, 3'b001, ALU code: A - B.
- FN_NAND, 3'b100, ALU code: ~(A & B).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  4  opcode from the fetch register.
- oprnd  in  4  operand nibble from the fetch register.
- prog_byte  in  8  current ROM output at PC.
- c_flag  in  1  registered carry flag.
- z_flag  in  1  registered zero flag.
- fetch_en  out  1  load fetch register this cycle.
- pc_inc  out  1  increment PC this cycle.
- pc_load  out  1  load PC from pc_addr this cycle.
- pc_addr  out  12  jump target {oprnd, prog_byte}.
- alu_fn  out  ALU_W  ALU function select.
- acc_en  out  1  accumulator write enable.
- flags_en  out  1  flag register write enable.
- oprnd_oe  out  1  drive oprnd onto the data bus.
- in_en  out  1  input port drives the data bus.
- out_en  out  1  output port latches accumulator.
- phase  out  2  state: 00 FETCH, 01 EXEC, 10 JADDR, 11 HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset is asynchronous and active-high. It forces FETCH. While reset is high, all strobes and pc_addr are 0, alu_fn is FN_PASSB and halted is 0.
- Reset asserted mid-instruction aborts the instruction. Strobes drop in the same cycle, with no further pc_load or acc_en.
- Strobes are decoded from the current state and inputs. Each strobe is high for exactly one clk cycle.
- State is registered. Default for every strobe is 0 and alu_fn defaults to FN_PASSB.
- FETCH:
  - fetch_en=1, pc_inc=1; next state EXEC.
- EXEC: decode on instr.
  - 0x0 NOP: no strobes.
  - 0x1 LIT: oprnd_oe, acc_en, FN_PASSB.
  - 0x2 ADDI: oprnd_oe, acc_en, flags_en, FN_ADD.
  - 0x3 SUBI: oprnd_oe, acc_en, flags_en, FN_SUB.
  - 0x4 NANDI: oprnd_oe, acc_en, flags_en, FN_NAND.
  - 0x5 CMPI: oprnd_oe, flags_en, FN_SUB. No acc_en.
  - 0x6 IN: in_en, acc_en, FN_PASSB.
  - 0x7 OUT: out_en.
  - 0x8–0xC (JMP, JC, JNC, JZ, JNZ): no strobes; next state JADDR.
  - 0xD, 0xE: reserved, behave as NOP.
  - 0xF HALT: next state HALT.
  - All other opcodes return to FETCH.
- JADDR:
  - PC already points at the second byte. pc_addr = {oprnd, prog_byte}, driven combinationally in this state; 0 otherwise.
  - Condition: JMP always; JC c_flag; JNC !c_flag; JZ z_flag; JNZ !z_flag. Flags are sampled in this cycle.
  - Taken: pc_load=1, pc_inc=0.
  - Not taken: pc_inc=1 to skip the address byte.
  - pc_load and pc_inc are never both high. Next state FETCH.
- HALT: absorbing state, left only by reset. All strobes 0, halted=1.
- Latency: non-jump instructions take 2 cycles (FETCH+EXEC); jumps take 3 cycles; HALT is entered 2 cycles after its fetch.
- The instr/oprnd latched by fetch_en in FETCH are the values decoded in the following EXEC.
- pc_addr wraps naturally over 12 bits; 0xFFF is a legal target.

Test Plan:
- Reset pulse mid-EXEC of ADDI: acc_en and flags_en drop immediately; after release, phase=00, fetch_en=1 and pc_inc=1 on the first cycle.
- Stream LIT 5, ADDI 3, OUT: the phase sequence 00,01 repeats. alu_fn is 000 then 011. acc_en is high in both EXECs, out_en is high in the third EXEC, and oprnd_oe is high only for LIT/ADDI.
- JMP with oprnd=0xA and prog_byte=0xBC: the cycle after EXEC is JADDR. pc_load=1, pc_addr=0xABC, pc_inc=0, then FETCH.
- JC with c_flag=0 and with c_flag=1 (same for JNZ with z_flag=1/0): not taken gives pc_inc=1, pc_load=0; taken gives pc_load=1 with the correct target. Target 0xFFF loads unchanged.
- CMPI 7: flags_en=1, alu_fn=001, acc_en=0. Opcodes 0xD/0xE produce no strobes for 2 cycles.
- HALT: phase=11 and halted=1 for 20+ cycles with all strobes 0 regardless of instr changes; reset returns to FETCH.

Source files
------------

// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decode_sequencer
// Purpose  : Control unit that sits after the fetch register. It steps the
//            machine through FETCH / EXEC / JADDR / HALT and decodes every
//            control strobe from the current phase and the fetched opcode.
//            Two-byte jumps take their 12-bit target from {oprnd, prog_byte}
//            once PC points at the second byte.
// Ports    : clk, reset (async, active-high)
//            instr, oprnd     - opcode / operand nibble from fetch register
//            prog_byte        - ROM byte at current PC (jump low byte)
//            c_flag, z_flag   - registered carry / zero flags
//            fetch_en, pc_inc, pc_load, pc_addr - fetch / PC control
//            alu_fn, acc_en, flags_en           - datapath control
//            oprnd_oe, in_en, out_en            - data-bus / I/O strobes
//            phase, halted                      - current state
// Revision : 1.0 - initial release
// ============================================================================
module decode_sequencer #(
  parameter int                 ALU_W    = 3,
  parameter logic [ALU_W-1:0]   FN_PASSB = 3'b000,
  parameter logic [ALU_W-1:0]   FN_ADD   = 3'b011,
  parameter logic [ALU_W-1:0]   FN_SUB   = 3'b001,
  parameter logic [ALU_W-1:0]   FN_NAND  = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic [3:0]       oprnd,
  input  logic [7:0]       prog_byte,
  input  logic             c_flag,
  input  logic             z_flag,
  output logic             fetch_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [11:0]      pc_addr,
  output logic [ALU_W-1:0] alu_fn,
  output logic             acc_en,
  output logic             flags_en,
  output logic             oprnd_oe,
  output logic             in_en,
  output logic             out_en,
  output logic [1:0]       phase,
  output logic             halted
);

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_JADDR = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       w_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // The fetch register still holds the jump opcode during JADDR, so the
  // condition is evaluated from instr directly; flags are sampled live.
  always_comb begin
    w_taken = 1'b0;
    case (instr)
      OP_JMP:  w_taken = 1'b1;
      OP_JC:   w_taken = c_flag;
      OP_JNC:  w_taken = ~c_flag;
      OP_JZ:   w_taken = z_flag;
      OP_JNZ:  w_taken = ~z_flag;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (instr >= OP_JMP && instr <= OP_JNZ) w_next_state = ST_JADDR;
        else if (instr == OP_HALT)              w_next_state = ST_HALT;
        else                                    w_next_state = ST_FETCH;
      end
      ST_JADDR: w_next_state = ST_FETCH;
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_FETCH;
    endcase
  end

  // Strobes are decoded combinationally and masked by reset, so asserting
  // reset mid-instruction drops every strobe in the same cycle.
  always_comb begin
    fetch_en = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_addr  = 12'h000;
    alu_fn   = FN_PASSB;
    acc_en   = 1'b0;
    flags_en = 1'b0;
    oprnd_oe = 1'b0;
    in_en    = 1'b0;
    out_en   = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          fetch_en = 1'b1;
          pc_inc   = 1'b1;
        end
        ST_EXEC: begin
          case (instr)
            OP_LIT: begin
              oprnd_oe = 1'b1;
              acc_en   = 1'b1;
            end
            OP_ADDI: begin
              oprnd_oe = 1'b1;
              acc_en   = 1'b1;
              flags_en = 1'b1;
              alu_fn   = FN_ADD;
            end
            OP_SUBI: begin
              oprnd_oe = 1'b1;
              acc_en   = 1'b1;
              flags_en = 1'b1;
              alu_fn   = FN_SUB;
            end
            OP_NANDI: begin
              oprnd_oe = 1'b1;
              acc_en   = 1'b1;
              flags_en = 1'b1;
              alu_fn   = FN_NAND;
            end
            OP_CMPI: begin
              oprnd_oe = 1'b1;
              flags_en = 1'b1;
              alu_fn   = FN_SUB;
            end
            OP_IN: begin
              in_en  = 1'b1;
              acc_en = 1'b1;
            end
            OP_OUT:  out_en = 1'b1;
            default: ;
          endcase
        end
        ST_JADDR: begin
          pc_addr = {oprnd, prog_byte};
          // Taken loads the target; not taken steps PC over the address byte.
          pc_load = w_taken;
          pc_inc  = ~w_taken;
        end
        ST_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_sequencer
// Purpose  : Self-checking bench for decode_sequencer. Instructions are run
//            one at a time; the expected per-cycle outputs come from an
//            instruction-level model (strobe table per opcode, jump rule).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_sequencer;

  localparam logic [2:0] PASSB = 3'b000;
  localparam logic [2:0] ADD   = 3'b011;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] NAND  = 3'b100;

  logic        clk;
  logic        reset;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  prog_byte;
  logic        c_flag;
  logic        z_flag;
  logic        fetch_en, pc_inc, pc_load;
  logic [11:0] pc_addr;
  logic [2:0]  alu_fn;
  logic        acc_en, flags_en, oprnd_oe, in_en, out_en;
  logic [1:0]  phase;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  decode_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .oprnd(oprnd),
    .prog_byte(prog_byte), .c_flag(c_flag), .z_flag(z_flag),
    .fetch_en(fetch_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_addr(pc_addr), .alu_fn(alu_fn), .acc_en(acc_en),
    .flags_en(flags_en), .oprnd_oe(oprnd_oe), .in_en(in_en),
    .out_en(out_en), .phase(phase), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fetch_en,pc_inc,pc_load,pc_addr,alu_fn,acc_en,flags_en,oprnd_oe,in_en,out_en,phase,halted}
  logic [25:0] obs;
  assign obs = {fetch_en, pc_inc, pc_load, pc_addr, alu_fn, acc_en, flags_en,
                oprnd_oe, in_en, out_en, phase, halted};

  function automatic logic [25:0] pack(input logic fe, input logic inc,
      input logic ld, input logic [11:0] addr, input logic [2:0] fn,
      input logic acc, input logic flg, input logic ooe, input logic ine,
      input logic oute, input logic [1:0] ph, input logic hlt);
    return {fe, inc, ld, addr, fn, acc, flg, ooe, ine, oute, ph, hlt};
  endfunction

  task automatic check_eq(input string tag, input logic [25:0] got,
                          input logic [25:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level expectations
  function automatic logic [25:0] exp_idle();
    return pack(0, 0, 0, 12'h0, PASSB, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction

  function automatic logic [25:0] exp_fetch();
    return pack(1, 1, 0, 12'h0, PASSB, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction

  function automatic logic [25:0] exp_exec(input logic [3:0] op);
    case (op)
      4'h1: return pack(0,0,0,12'h0, PASSB, 1,0,1,0,0, 2'b01, 0); // LIT
      4'h2: return pack(0,0,0,12'h0, ADD,   1,1,1,0,0, 2'b01, 0); // ADDI
      4'h3: return pack(0,0,0,12'h0, SUB,   1,1,1,0,0, 2'b01, 0); // SUBI
      4'h4: return pack(0,0,0,12'h0, NAND,  1,1,1,0,0, 2'b01, 0); // NANDI
      4'h5: return pack(0,0,0,12'h0, SUB,   0,1,1,0,0, 2'b01, 0); // CMPI
      4'h6: return pack(0,0,0,12'h0, PASSB, 1,0,0,1,0, 2'b01, 0); // IN
      4'h7: return pack(0,0,0,12'h0, PASSB, 0,0,0,0,1, 2'b01, 0); // OUT
      default: return pack(0,0,0,12'h0, PASSB, 0,0,0,0,0, 2'b01, 0);
    endcase
  endfunction

  function automatic logic [25:0] exp_jaddr(input logic [3:0] op,
      input logic [3:0] opr, input logic [7:0] pb, input logic c, input logic z);
    logic tk;
    case (op)
      4'h8:    tk = 1'b1;
      4'h9:    tk = c;
      4'hA:    tk = !c;
      4'hB:    tk = z;
      default: tk = !z;
    endcase
    return pack(0, !tk, tk, {opr, pb}, PASSB, 0, 0, 0, 0, 0, 2'b10, 0);
  endfunction

  function automatic logic [25:0] exp_halt();
    return pack(0, 0, 0, 12'h0, PASSB, 0, 0, 0, 0, 0, 2'b11, 1);
  endfunction

  // Starts and ends one time unit after a rising edge, at a cycle boundary.
  task automatic run_instr(input string tag, input logic [3:0] op,
      input logic [3:0] opr, input logic [7:0] pb, input logic c, input logic z);
    instr = op; oprnd = opr; prog_byte = pb; c_flag = c; z_flag = z;
    @(negedge clk); check_eq({tag, "_fetch"}, obs, exp_fetch());
    @(posedge clk); #1;
    @(negedge clk); check_eq({tag, "_exec"}, obs, exp_exec(op));
    @(posedge clk); #1;
    if (op >= 4'h8 && op <= 4'hC) begin
      @(negedge clk); check_eq({tag, "_jaddr"}, obs, exp_jaddr(op, opr, pb, c, z));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; instr = 4'h0; oprnd = 4'h0; prog_byte = 8'h00;
    c_flag = 1'b0; z_flag = 1'b0;
    @(negedge clk); check_eq("reset", obs, exp_idle());
    @(negedge clk); check_eq("reset_hold", obs, exp_idle());
    @(posedge clk); #1 reset = 1'b0;

    // Reset pulse in the middle of ADDI's EXEC
    instr = 4'h2; oprnd = 4'h3;
    @(negedge clk); check_eq("rst_mid_fetch", obs, exp_fetch());
    @(posedge clk); #1;
    @(negedge clk); check_eq("rst_mid_exec", obs, exp_exec(4'h2));
    #1 reset = 1'b1;
    #1 check_eq("rst_mid_drop", obs, exp_idle());
    @(posedge clk); #1 check_eq("rst_mid_held", obs, exp_idle());
    reset = 1'b0;
    @(negedge clk); check_eq("rst_release_fetch", obs, exp_fetch());
    @(posedge clk); #1;
    @(negedge clk); check_eq("rst_release_exec", obs, exp_exec(4'h2));
    @(posedge clk); #1;

    // Directed stream and jumps
    run_instr("lit5",   4'h1, 4'h5, 8'h00, 0, 0);
    run_instr("addi3",  4'h2, 4'h3, 8'h00, 0, 0);
    run_instr("out",    4'h7, 4'h0, 8'h00, 0, 0);
    run_instr("jmp",    4'h8, 4'hA, 8'hBC, 0, 0);
    run_instr("jc_nt",  4'h9, 4'h1, 8'h23, 0, 0);
    run_instr("jc_t",   4'h9, 4'h4, 8'h56, 1, 0);
    run_instr("jnz_nt", 4'hC, 4'h7, 8'h89, 0, 1);
    run_instr("jnz_t",  4'hC, 4'hF, 8'hFF, 0, 0);
    run_instr("jmp_fff",4'h8, 4'hF, 8'hFF, 1, 1);
    run_instr("cmpi7",  4'h5, 4'h7, 8'h00, 0, 0);
    run_instr("rsv_d",  4'hD, 4'h2, 8'h11, 1, 1);
    run_instr("rsv_e",  4'hE, 4'h9, 8'h22, 0, 1);
    run_instr("in",     4'h6, 4'h0, 8'h00, 0, 0);
    run_instr("nandi",  4'h4, 4'hC, 8'h00, 0, 0);
    run_instr("subi",   4'h3, 4'h1, 8'h00, 0, 0);
    run_instr("nop",    4'h0, 4'h6, 8'h00, 0, 0);

    // Randomized instruction stream (HALT excluded until the end)
    for (int i = 0; i < 200; i++) begin
      run_instr("rand", 4'($urandom_range(0, 14)), 4'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
    end

    // HALT is absorbing regardless of inputs
    run_instr("halt", 4'hF, 4'h0, 8'h00, 0, 0);
    for (int i = 0; i < 25; i++) begin
      instr = 4'($urandom); oprnd = 4'($urandom); prog_byte = 8'($urandom);
      c_flag = 1'($urandom); z_flag = 1'($urandom);
      @(negedge clk); check_eq("halt_hold", obs, exp_halt());
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1 check_eq("halt_reset", obs, exp_idle());
    @(posedge clk); #1 reset = 1'b0;
    instr = 4'h1;
    @(negedge clk); check_eq("halt_exit_fetch", obs, exp_fetch());
    @(posedge clk); #1;
    @(negedge clk); check_eq("halt_exit_exec", obs, exp_exec(4'h1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
